uart_mmio_fifo: RTL

Memory-mapped UART peripheral on the CPU data bus, successor to the single-byte UART. It adds parametrised TX/RX FIFOs, sticky error flags with write-1-to-clear, framing checking, and an optional interrupt. The CPU reaches it through the same MemRead/MemWrite/Address/Write_data/Read_data port as the other peripherals. Serial format is fixed 8N1, LSB first.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_mmio_fifo_if.sv | 21 ++
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_mmio_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS/CTRL bit positions and serial FSM state encodings.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFF = 32'd0;
  localparam logic [31:0] RXDATA_OFF = 32'd4;
  localparam logic [31:0] STATUS_OFF = 32'd8;
  localparam logic [31:0] CTRL_OFF   = 32'd12;

  localparam int ST_RX_NE    = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVF   = 5;
  localparam int ST_TX_OVF   = 6;
  localparam int ST_FRM_ERR  = 7;
  localparam int ST_CNT_LSB  = 16;

  localparam int CT_RX_IE = 0;
  localparam int CT_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_fifo_if.sv
// CPU data-bus port shared by the memory-mapped peripherals.
// The CPU side is master; the peripheral side is slave.
interface uart_mmio_fifo_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport master (
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data
  );

  modport slave (
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with power-of-2 depth.
// Full/empty are evaluated before this cycle's pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop & ~empty;
  // a pop on a full FIFO frees the slot the push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and sticky error flags.
// Define UART_IRQ_EN to build the CTRL register and the registered irq.
module uart_mmio_fifo
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 10417,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_mmio_fifo_if.slave  bus,
  input  logic             rx_serial,
  output logic             tx_serial,
  output logic             irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic sel_tx, sel_rx, sel_st, sel_ct;
  logic wr_tx, rd_rx, wr_st;

  assign sel_tx = bus.Address == BASE_ADDR + TXDATA_OFF;
  assign sel_rx = bus.Address == BASE_ADDR + RXDATA_OFF;
  assign sel_st = bus.Address == BASE_ADDR + STATUS_OFF;
  assign sel_ct = bus.Address == BASE_ADDR + CTRL_OFF;
  assign wr_tx  = bus.MemWrite & sel_tx;
  assign rd_rx  = bus.MemRead & sel_rx;
  assign wr_st  = bus.MemWrite & sel_st;

  logic          tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [NW-1:0] tx_count;
  logic          rx_push, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [NW-1:0] rx_count;

  tx_state_e     tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_q, tx_n;
  logic          tx_busy;

  rx_state_e     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_s1, rx_s2, rx_d;
  logic          frm_set;

  logic rx_ovf, tx_ovf, frm_err;
  logic [31:0] status, ctrl;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .push(wr_tx), .pop(tx_pop),
    .din(bus.Write_data[7:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .push(rx_push), .pop(rd_rx),
    .din(rx_sh), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign tx_busy   = tx_st != TX_IDLE;
  assign tx_serial = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
      tx_q   <= tx_n;
    end
  end

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_n     = tx_q;
    tx_pop   = 1'b0;
    unique case (tx_st)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_n  = tx_dout;
          tx_cnt_n = '0;
          tx_st_n  = TX_START;
          tx_n     = 1'b0;
        end
      end
      TX_START: begin
        tx_cnt_n = tx_cnt + ONE;
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_bit_n = '0;
          tx_st_n  = TX_DATA;
          tx_n     = tx_sh[0];
        end
      end
      TX_DATA: begin
        tx_cnt_n = tx_cnt + ONE;
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_st_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_sh_n  = tx_sh >> 1;
            tx_n     = tx_sh[1];
          end
        end
      end
      TX_STOP: begin
        tx_cnt_n = tx_cnt + ONE;
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_st_n  = TX_IDLE;
        end
      end
      default: tx_st_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_d   <= 1'b1;
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1  <= rx_serial;
      rx_s2  <= rx_s1;
      rx_d   <= rx_s2;
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_push  = 1'b0;
    frm_set  = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        if (rx_d & ~rx_s2) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_n = rx_cnt + ONE;
        if (rx_cnt == HALF) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_n = rx_cnt + ONE;
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          rx_bit_n = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st_n = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_n = rx_cnt + ONE;
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          rx_push  = rx_s2;
          frm_set  = ~rx_s2;
        end
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  // a set event in the same cycle wins over a write-1 clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf  <= 1'b0;
      tx_ovf  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_ovf  <= (rx_push & rx_full & ~rd_rx) |
                 (rx_ovf & ~(wr_st & bus.Write_data[ST_RX_OVF]));
      tx_ovf  <= (wr_tx & tx_full & ~tx_pop) |
                 (tx_ovf & ~(wr_st & bus.Write_data[ST_TX_OVF]));
      frm_err <= frm_set |
                 (frm_err & ~(wr_st & bus.Write_data[ST_FRM_ERR]));
    end
  end

  always_comb begin
    status                     = '0;
    status[ST_RX_NE]           = ~rx_empty;
    status[ST_RX_FULL]         = rx_full;
    status[ST_TX_FULL]         = tx_full;
    status[ST_TX_EMPTY]        = tx_empty;
    status[ST_TX_BUSY]         = tx_busy;
    status[ST_RX_OVF]          = rx_ovf;
    status[ST_TX_OVF]          = tx_ovf;
    status[ST_FRM_ERR]         = frm_err;
    status[ST_CNT_LSB +: 8]    = 8'(rx_count);
  end

`ifdef UART_IRQ_EN
  logic wr_ct, rx_ie, tx_ie, irq_q;

  assign wr_ct = bus.MemWrite & sel_ct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ct) begin
        rx_ie <= bus.Write_data[CT_RX_IE];
        tx_ie <= bus.Write_data[CT_TX_IE];
      end
      irq_q <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy);
    end
  end

  always_comb begin
    ctrl           = '0;
    ctrl[CT_RX_IE] = rx_ie;
    ctrl[CT_TX_IE] = tx_ie;
  end

  assign irq = irq_q;
`else
  assign ctrl = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    bus.Read_data = '0;
    if (bus.MemRead) begin
      unique case (1'b1)
        sel_rx:  bus.Read_data = rx_empty ? '0 : {24'b0, rx_dout};
        sel_st:  bus.Read_data = status;
        sel_ct:  bus.Read_data = ctrl;
        default: bus.Read_data = '0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.Write_data[31:8], tx_count};

endmodule
